example7_5_input_cond: RTL and testbench

Input conditioning stage directly upstream of the `example7_5` f/g lookup FSM. It synchronises the asynchronous switch inputs `x1`, `x2` and `x3` into the `Clock` domain and debounces each one. It then priority-encodes the stable inputs into the 2-bit `index` that the lookup stage decodes on every `Clock` edge. A one-cycle `index_valid` pulse flags each change of `index` for downstream logging and verification.

---
 rtl/example7_5_pkg.sv | 28 ++
 rtl/example7_5_debounce_cell.sv | 72 +++++++
 rtl/example7_5_input_cond.sv | 74 +++++++
 tb/tb_example7_5_input_cond.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/example7_5_pkg.sv
// example7_5 shared types: index encoding, default debounce depth
// and the priority encoder used by the input conditioning stage.
package example7_5_pkg;

  typedef logic [1:0] index_t;

  localparam index_t IDX_NONE = 2'd0;
  localparam index_t IDX_X1   = 2'd1;
  localparam index_t IDX_X2   = 2'd2;
  localparam index_t IDX_X3   = 2'd3;

  localparam int unsigned DEBOUNCE_DEFAULT = 4;

  // x3 wins over x2, x2 over x1
  function automatic index_t encode(
    input logic st3,
    input logic st2,
    input logic st1
  );
    index_t r;
    if (st3)      r = IDX_X3;
    else if (st2) r = IDX_X2;
    else if (st1) r = IDX_X1;
    else          r = IDX_NONE;
    return r;
  endfunction

endpackage

// File: rtl/example7_5_debounce_cell.sv
// Two-flop synchroniser plus optional debounce for one switch input.
// Ports: clk, rst (sync, active-high), d (raw async), stable (clean).
// Debounce counter compiled only with EXAMPLE7_5_DEBOUNCE_EN defined.
module example7_5_debounce_cell
  import example7_5_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic stable
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

`ifdef EXAMPLE7_5_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          st_q, st_d;

  // any return to the stable level before the threshold
  // throws the partial count away
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    if (s2_q == st_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      st_d  = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  assign stable = st_q;
`else
  logic [7:0] unused_cfg;
  assign unused_cfg = 8'(DEBOUNCE_CYCLES);
  assign stable     = s2_q;
`endif

endmodule

// File: rtl/example7_5_input_cond.sv
// Input conditioning for the example7_5 lookup FSM: sync, debounce,
// priority-encode x3>x2>x1 into a registered index with change pulse.
// Ports: Clock, Reset (sync, active-high), x1..x3 raw switches,
// index (2b registered), index_valid (1-cycle pulse on change).
// Build option: EXAMPLE7_5_DEBOUNCE_EN enables the debounce counters.
module example7_5_input_cond
  import example7_5_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       x1,
  input  logic       x2,
  input  logic       x3,
  output logic [1:0] index,
  output logic       index_valid
);

  logic st1, st2, st3;

  example7_5_debounce_cell #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_cell1 (
    .clk   (Clock),
    .rst   (Reset),
    .d     (x1),
    .stable(st1)
  );

  example7_5_debounce_cell #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_cell2 (
    .clk   (Clock),
    .rst   (Reset),
    .d     (x2),
    .stable(st2)
  );

  example7_5_debounce_cell #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_cell3 (
    .clk   (Clock),
    .rst   (Reset),
    .d     (x3),
    .stable(st3)
  );

  index_t enc;
  index_t index_q, index_d;
  logic   valid_q, valid_d;

  // pulse only on a change of the encoded value, so lower-priority
  // toggles under a held higher input stay silent
  always_comb begin
    enc     = encode(st3, st2, st1);
    index_d = enc;
    valid_d = (enc != index_q);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      index_q <= IDX_NONE;
      valid_q <= 1'b0;
    end else begin
      index_q <= index_d;
      valid_q <= valid_d;
    end
  end

  assign index       = index_q;
  assign index_valid = valid_q;

endmodule

// File: tb/tb_example7_5_input_cond.sv
// Directed self-checking bench for example7_5_input_cond.
// Latency follows the EXAMPLE7_5_DEBOUNCE_EN build option.
module tb_example7_5_input_cond;

`ifdef EXAMPLE7_5_DEBOUNCE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  logic       Clock = 1'b0;
  logic       Reset;
  logic       x1, x2, x3;
  logic [1:0] index;
  logic       index_valid;

  int checks = 0;
  int errors = 0;
  logic [1:0] cur = 2'd0;

  example7_5_input_cond dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .x1         (x1),
    .x2         (x2),
    .x3         (x3),
    .index      (index),
    .index_valid(index_valid)
  );

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] ei,
                     input logic ev);
    checks++;
    assert (index === ei) else begin
      errors++;
      $error("FAIL %s index got %0d want %0d", tag, index, ei);
    end
    checks++;
    assert (index_valid === ev) else begin
      errors++;
      $error("FAIL %s valid got %0b want %0b", tag, index_valid, ev);
    end
  endtask

  // inputs already applied before the next edge (E1)
  task automatic expect_change(input string tag, input logic [1:0] nv);
    for (int k = 1; k < LAT; k++) begin
      step();
      chk({tag, "_hold"}, cur, 1'b0);
    end
    step();
    chk({tag, "_edge"}, nv, 1'b1);
    step();
    chk({tag, "_after"}, nv, 1'b0);
    cur = nv;
  endtask

  initial begin
    Reset = 1'b1;
    x1 = 1'b1; x2 = 1'b1; x3 = 1'b1;
    step();
    chk("rst0", 2'd0, 1'b0);
    step();
    chk("rst1", 2'd0, 1'b0);
    Reset = 1'b0;
    expect_change("rel_x3", 2'd3);

    x1 = 1'b0; x2 = 1'b0; x3 = 1'b0;
    expect_change("all_low", 2'd0);

    x2 = 1'b1;
    expect_change("x2_rise", 2'd2);
    x2 = 1'b0;
    expect_change("x2_fall", 2'd0);

`ifdef EXAMPLE7_5_DEBOUNCE_EN
    x1 = 1'b1;
    for (int k = 0; k < 3; k++) step();
    x1 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("glitch3", 2'd0, 1'b0);
    end

    x1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("g4_hi", 2'd0, 1'b0);
    end
    x1 = 1'b0;
    step(); chk("g4_e5", 2'd0, 1'b0);
    step(); chk("g4_e6", 2'd0, 1'b0);
    step(); chk("g4_e7", 2'd1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("g4_held", 2'd1, 1'b0);
    end
    step(); chk("g4_e11", 2'd0, 1'b1);
    step(); chk("g4_e12", 2'd0, 1'b0);
`else
    x1 = 1'b1;
    step();
    x1 = 1'b0;
    chk("p1_e1", 2'd0, 1'b0);
    step(); chk("p1_e2", 2'd0, 1'b0);
    step(); chk("p1_e3", 2'd1, 1'b1);
    step(); chk("p1_e4", 2'd0, 1'b1);
    step(); chk("p1_e5", 2'd0, 1'b0);
`endif
    cur = 2'd0;

    x3 = 1'b1;
    expect_change("prio_x3", 2'd3);
    for (int k = 0; k < 24; k++) begin
      x1 = k[0];
      x2 = k[2];
      step();
      chk("prio_tog", 2'd3, 1'b0);
    end
    x1 = 1'b0; x2 = 1'b0;
    for (int k = 0; k < 12; k++) step();
    chk("prio_hold", 2'd3, 1'b0);
    x3 = 1'b0;
    expect_change("prio_off", 2'd0);

    x3 = 1'b1;
    step(); step(); step();
`ifdef EXAMPLE7_5_DEBOUNCE_EN
    chk("mid_e3", 2'd0, 1'b0);
`endif
    Reset = 1'b1;
    step();
    chk("mid_rst", 2'd0, 1'b0);
    Reset = 1'b0;
    cur = 2'd0;
    expect_change("mid_rel", 2'd3);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
